// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - in-order branch prediction queue with ID-stage resolution, predictor update and redirect
//
// Holds every prediction issued at IF in a circular queue. When a branch
// resolves in ID, computes the real direction, checks it against the queue
// head and drives a registered predictor update plus redirect/flush on a
// mispredict.
//
// Optional feature macro: BRU_PERF_CNT_EN (adds saturating perf counters).
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   push_valid/pc/pdt_res/which/history   prediction issued at IF
//   full, empty              queue occupancy flags (from registered pointers)
//   res_valid/pc/funct3/rs1/rs2/imm       branch resolving in ID
//   upd_valid/pc/taken/pdt_true/which/history   predictor update packet
//   redirect_valid, redirect_pc, flush    fetch restart on mispredict
//   order_err                sticky protocol-error flag
//   perf_br_cnt, perf_mis_cnt   (BRU_PERF_CNT_EN only) resolution/mispredict counts

module branch_resolve_unit #(
  parameter int DEPTH  = 4,
  parameter int HIST_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  input  logic [31:0]       push_pc,
  input  logic              push_pdt_res,
  input  logic              push_which,
  input  logic [HIST_W-1:0] push_history,
  output logic              full,
  output logic              empty,
  input  logic              res_valid,
  input  logic [31:0]       res_pc,
  input  logic [2:0]        res_funct3,
  input  logic [31:0]       res_rs1,
  input  logic [31:0]       res_rs2,
  input  logic [31:0]       res_imm,
  output logic              upd_valid,
  output logic [31:0]       upd_pc,
  output logic              upd_taken,
  output logic              upd_pdt_true,
  output logic              upd_which,
  output logic [HIST_W-1:0] upd_history,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic              flush,
  output logic              order_err
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]       perf_br_cnt,
  output logic [31:0]       perf_mis_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry an extra wrap bit to distinguish full from empty.
  logic [AW:0] wp;
  logic [AW:0] rp;

  logic [31:0]       q_pc   [DEPTH];
  logic              q_pdt  [DEPTH];
  logic              q_which[DEPTH];
  logic [HIST_W-1:0] q_hist [DEPTH];

  logic [31:0]       head_pc;
  logic              head_pdt;
  logic              head_which;
  logic [HIST_W-1:0] head_hist;

  logic        actual;
  logic [31:0] target;
  logic        pop;
  logic        pc_mismatch;
  logic        pdt_ok;
  logic        mispredict;
  logic        push_ok;
  logic        push_drop;
  logic [AW:0] rp_next;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);

  assign head_pc    = q_pc[rp[AW-1:0]];
  assign head_pdt   = q_pdt[rp[AW-1:0]];
  assign head_which = q_which[rp[AW-1:0]];
  assign head_hist  = q_hist[rp[AW-1:0]];

  always_comb begin
    actual = 1'b0;
    case (res_funct3)
      3'b000:  actual = (res_rs1 == res_rs2);
      3'b001:  actual = (res_rs1 != res_rs2);
      3'b100:  actual = ($signed(res_rs1) <  $signed(res_rs2));
      3'b101:  actual = ($signed(res_rs1) >= $signed(res_rs2));
      3'b110:  actual = (res_rs1 <  res_rs2);
      3'b111:  actual = (res_rs1 >= res_rs2);
      default: actual = 1'b0;
    endcase
  end

  assign target = actual ? (res_pc + res_imm) : (res_pc + 32'd4);

  assign pop         = res_valid && !empty;
  assign pc_mismatch = pop && (res_pc != head_pc);
  assign pdt_ok      = pop && !pc_mismatch && (actual == head_pdt);
  // An out-of-order or empty-queue resolution is handled as a mispredict so
  // fetch always restarts at the architecturally correct PC.
  assign mispredict  = res_valid && !pdt_ok;
  // A push in a flushing cycle is on the wrong path and is dropped.
  assign push_ok     = push_valid && (!full || pop) && !mispredict;
  assign push_drop   = push_valid && full && !pop;
  assign rp_next     = pop ? (rp + (AW+1)'(1)) : rp;

  // Queue contents need no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      q_pc[wp[AW-1:0]]    <= push_pc;
      q_pdt[wp[AW-1:0]]   <= push_pdt_res;
      q_which[wp[AW-1:0]] <= push_which;
      q_hist[wp[AW-1:0]]  <= push_history;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp             <= '0;
      rp             <= '0;
      upd_valid      <= 1'b0;
      upd_pc         <= '0;
      upd_taken      <= 1'b0;
      upd_pdt_true   <= 1'b0;
      upd_which      <= 1'b0;
      upd_history    <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      order_err      <= 1'b0;
    end else begin
      rp <= rp_next;
      if (mispredict) begin
        wp <= rp_next;
      end else if (push_ok) begin
        wp <= wp + (AW+1)'(1);
      end

      if (push_drop || pc_mismatch || (res_valid && empty)) begin
        order_err <= 1'b1;
      end

      upd_valid      <= pop;
      redirect_valid <= mispredict;
      flush          <= mispredict;
      if (res_valid) begin
        upd_pc       <= pc_mismatch ? res_pc : head_pc;
        upd_taken    <= actual;
        upd_pdt_true <= pdt_ok;
        upd_which    <= head_which;
        upd_history  <= head_hist;
        redirect_pc  <= target;
      end
    end
  end

`ifdef BRU_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_br_cnt  <= '0;
      perf_mis_cnt <= '0;
    end else begin
      if (upd_valid && (perf_br_cnt != 32'hFFFF_FFFF)) begin
        perf_br_cnt <= perf_br_cnt + 32'd1;
      end
      if (redirect_valid && (perf_mis_cnt != 32'hFFFF_FFFF)) begin
        perf_mis_cnt <= perf_mis_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - scoreboard testbench for branch_resolve_unit

module tb_branch_resolve_unit;

  logic        clk;
  logic        rst;
  logic        push_valid;
  logic [31:0] push_pc;
  logic        push_pdt_res;
  logic        push_which;
  logic [9:0]  push_history;
  logic        full;
  logic        empty;
  logic        res_valid;
  logic [31:0] res_pc;
  logic [2:0]  res_funct3;
  logic [31:0] res_rs1;
  logic [31:0] res_rs2;
  logic [31:0] res_imm;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_pdt_true;
  logic        upd_which;
  logic [9:0]  upd_history;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        order_err;
`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_br_cnt;
  logic [31:0] perf_mis_cnt;
`endif

  branch_resolve_unit #(.DEPTH(4), .HIST_W(10)) dut (
    .clk(clk), .rst(rst),
    .push_valid(push_valid), .push_pc(push_pc), .push_pdt_res(push_pdt_res),
    .push_which(push_which), .push_history(push_history),
    .full(full), .empty(empty),
    .res_valid(res_valid), .res_pc(res_pc), .res_funct3(res_funct3),
    .res_rs1(res_rs1), .res_rs2(res_rs2), .res_imm(res_imm),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_pdt_true(upd_pdt_true), .upd_which(upd_which), .upd_history(upd_history),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .order_err(order_err)
`ifdef BRU_PERF_CNT_EN
    , .perf_br_cnt(perf_br_cnt), .perf_mis_cnt(perf_mis_cnt)
`endif
  );

  typedef struct {
    logic        upd;
    logic [31:0] pc;
    logic        taken;
    logic        ptrue;
    logic        which;
    logic [9:0]  hist;
    logic        redir;
    logic [31:0] rpc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_br   = 0;
  int   exp_mis  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops one expectation whenever the DUT presents any strobe.
  always @(negedge clk) begin
    if (!rst && (upd_valid || redirect_valid || flush)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: upd_valid=%0b redirect_valid=%0b required no output",
                 upd_valid, redirect_valid);
      end else begin
        mon_e = exp_q.pop_front();
        chk("upd_valid", 32'(upd_valid), 32'(mon_e.upd));
        if (mon_e.upd) begin
          chk("upd_pc", upd_pc, mon_e.pc);
          chk("upd_taken", 32'(upd_taken), 32'(mon_e.taken));
          chk("upd_pdt_true", 32'(upd_pdt_true), 32'(mon_e.ptrue));
          chk("upd_which", 32'(upd_which), 32'(mon_e.which));
          chk("upd_history", 32'(upd_history), 32'(mon_e.hist));
        end
        chk("redirect_valid", 32'(redirect_valid), 32'(mon_e.redir));
        chk("flush", 32'(flush), 32'(mon_e.redir));
        if (mon_e.redir) chk("redirect_pc", redirect_pc, mon_e.rpc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    push_valid = 1'b0;
    res_valid  = 1'b0;
  endtask

  task automatic set_push(input logic [31:0] pc, input logic pdt, input logic which, input logic [9:0] hist);
    push_valid   = 1'b1;
    push_pc      = pc;
    push_pdt_res = pdt;
    push_which   = which;
    push_history = hist;
  endtask

  task automatic set_res(input logic [31:0] pc, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm);
    res_valid  = 1'b1;
    res_pc     = pc;
    res_funct3 = f3;
    res_rs1    = a;
    res_rs2    = b;
    res_imm    = imm;
  endtask

  task automatic expect_out(input logic upd, input logic [31:0] pc, input logic taken,
                            input logic ptrue, input logic which, input logic [9:0] hist,
                            input logic redir, input logic [31:0] rpc);
    exp_t e;
    e.upd = upd; e.pc = pc; e.taken = taken; e.ptrue = ptrue;
    e.which = which; e.hist = hist; e.redir = redir; e.rpc = rpc;
    exp_q.push_back(e);
    if (upd)   exp_br++;
    if (redir) exp_mis++;
  endtask

  task automatic do_reset(input logic check_perf);
    step();
    step();
`ifdef BRU_PERF_CNT_EN
    if (check_perf) begin
      chk("perf_br_cnt", perf_br_cnt, 32'(exp_br));
      chk("perf_mis_cnt", perf_mis_cnt, 32'(exp_mis));
    end
`else
    if (check_perf) exp_br = 0;
`endif
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_br  = 0;
    exp_mis = 0;
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    push_valid = 1'b0; push_pc = '0; push_pdt_res = 1'b0; push_which = 1'b0; push_history = '0;
    res_valid = 1'b0; res_pc = '0; res_funct3 = '0; res_rs1 = '0; res_rs2 = '0; res_imm = '0;
    do_reset(1'b0);

    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_order_err", 32'(order_err), 32'd0);
    chk("rst_upd_valid", 32'(upd_valid), 32'd0);
    chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);

    // beq taken, predicted taken
    set_push(32'h100, 1'b1, 1'b0, 10'h3);
    step();
    chk("t1_not_empty", 32'(empty), 32'd0);
    set_res(32'h100, 3'b000, 32'd5, 32'd5, 32'h20);
    expect_out(1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 10'h3, 1'b0, 32'h0);
    step();
    chk("t1_empty", 32'(empty), 32'd1);
    step();

    // bltu taken (1 <u 0xFFFFFFFF), predicted not taken, negative immediate
    set_push(32'h200, 1'b0, 1'b1, 10'h155);
    step();
    set_res(32'h200, 3'b110, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFF0);
    expect_out(1'b1, 32'h200, 1'b1, 1'b0, 1'b1, 10'h155, 1'b1, 32'h1F0);
    step();
    step();

    // three queued, first mispredicts while a wrong-path push arrives
    set_push(32'h10, 1'b0, 1'b0, 10'h1); step();
    set_push(32'h14, 1'b0, 1'b0, 10'h2); step();
    set_push(32'h18, 1'b0, 1'b0, 10'h3); step();
    set_push(32'h1C, 1'b0, 1'b0, 10'h4);
    set_res(32'h10, 3'b000, 32'd7, 32'd7, 32'd8);
    expect_out(1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 10'h1, 1'b1, 32'h18);
    step();
    chk("t3_empty", 32'(empty), 32'd1);
    chk("t3_order_err", 32'(order_err), 32'd0);
    step();

    // fill to DEPTH, overflow push, then push+pop while full, then drain
    for (int i = 0; i < 4; i++) begin
      set_push(32'h40 + 32'(4 * i), 1'b0, 1'b1, 10'(32'h40 + 32'(4 * i)));
      step();
    end
    chk("t4_full", 32'(full), 32'd1);
    chk("t4_order_err_before", 32'(order_err), 32'd0);
    set_push(32'h60, 1'b0, 1'b1, 10'h60);
    step();
    chk("t4_order_err_drop", 32'(order_err), 32'd1);
    chk("t4_full_after_drop", 32'(full), 32'd1);
    set_push(32'h50, 1'b0, 1'b1, 10'h50);
    set_res(32'h40, 3'b010, 32'd0, 32'd0, 32'd4);
    expect_out(1'b1, 32'h40, 1'b0, 1'b1, 1'b1, 10'h40, 1'b0, 32'h0);
    step();
    chk("t4_full_push_pop", 32'(full), 32'd1);
    // all not taken and predicted not taken
    set_res(32'h44, 3'b100, 32'd3, 32'hFFFF_FFFB, 32'h8);
    expect_out(1'b1, 32'h44, 1'b0, 1'b1, 1'b1, 10'h44, 1'b0, 32'h0);
    step();
    set_res(32'h48, 3'b111, 32'd1, 32'd2, 32'h8);
    expect_out(1'b1, 32'h48, 1'b0, 1'b1, 1'b1, 10'h48, 1'b0, 32'h0);
    step();
    set_res(32'h4C, 3'b011, 32'd1, 32'd1, 32'h8);
    expect_out(1'b1, 32'h4C, 1'b0, 1'b1, 1'b1, 10'h4C, 1'b0, 32'h0);
    step();
    set_res(32'h50, 3'b001, 32'd9, 32'd9, 32'h8);
    expect_out(1'b1, 32'h50, 1'b0, 1'b1, 1'b1, 10'h50, 1'b0, 32'h0);
    step();
    chk("t4_drained", 32'(empty), 32'd1);

    // out-of-order resolution: bge signed taken (-1 >= -2), pc mismatch
    do_reset(1'b1);
    set_push(32'h500, 1'b1, 1'b0, 10'h5); step();
    set_push(32'h508, 1'b1, 1'b0, 10'h6); step();
    set_res(32'h504, 3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h10);
    expect_out(1'b1, 32'h504, 1'b1, 1'b0, 1'b0, 10'h5, 1'b1, 32'h514);
    step();
    chk("t5_order_err", 32'(order_err), 32'd1);
    chk("t5_empty", 32'(empty), 32'd1);

    // resolution with empty queue: bne taken
    do_reset(1'b1);
    chk("t6_order_err_clear", 32'(order_err), 32'd0);
    set_res(32'h300, 3'b001, 32'd1, 32'd2, 32'h40);
    expect_out(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 10'h0, 1'b1, 32'h340);
    step();
    chk("t6_order_err", 32'(order_err), 32'd1);
    chk("t6_upd_valid", 32'(upd_valid), 32'd0);
    chk("t6_redirect_valid", 32'(redirect_valid), 32'd1);

    // reset with entries in flight
    set_push(32'h700, 1'b1, 1'b0, 10'h7); step();
    set_push(32'h704, 1'b1, 1'b0, 10'h8); step();
    chk("t7_not_empty", 32'(empty), 32'd0);
    do_reset(1'b1);
    chk("t7_empty", 32'(empty), 32'd1);
    chk("t7_order_err", 32'(order_err), 32'd0);
    chk("t7_upd_valid", 32'(upd_valid), 32'd0);
    chk("t7_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("t7_flush", 32'(flush), 32'd0);
`ifdef BRU_PERF_CNT_EN
    chk("t7_perf_br_rst", perf_br_cnt, 32'd0);
    chk("t7_perf_mis_rst", perf_mis_cnt, 32'd0);
`endif

    step();
    step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
